moonbase_bus_bridge: RTL and testbench
======================================

Name: moonbase_bus_bridge

Overview:
- On-die external-bus target that sits directly downstream of the 8-bit moonbase CPU.
- Consumes the CPU's multiplexed 8-bit output bus and produces its 6 read-data input bits.
- Contains the 7-bit address latch, a nibble-paired code/data SRAM (512×4) and a 2-bit device port.
- Includes a nibble-serial program loader that holds the CPU in reset while it fills code memory.

Parameters:
- ABITS, 7, width of the latched bus address.
- DEV_W, 4, device write-data width; must equal the bus data nibble width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cpu_bus  in  8  CPU io_out. [7]=strobe; strobe=1: [6:0]=address. strobe=0: [6]=bank (1 code, 0 data), [5]=ram_we_n, [4]=dev_we_n, [3:0]=wdata.
- cpu_rd  out  6  to CPU io_in[7:2]. [3:0]=ram nibble, [5:4]=dev_rdata.
- cpu_reset  out  1  to CPU io_in[1].
- load_en  in  1  loader active.
- load_valid  in  1  load_data qualifier.
- load_data  in  4  nibble to load.
- dev_addr  out  7  latched address, to devices.
- dev_wdata  out  4  device write data.
- dev_we  out  1  one-cycle device write pulse.
- dev_rdata  in  2  device read data at dev_addr.

Behaviour:
- Decided: reset is reset, synchronous, active-high; clock is clk.
- Reset values:
  - addr latch=0, nib=0, load_ptr=0, dev_we=0, dev_wdata=0.
  - cpu_reset=1 during reset and for 1 cycle after.
  - Memory contents are not reset.
- Address latch: on a clk edge with cpu_bus[7]=1, latch<=cpu_bus[6:0] and nib<=0.
- Nibble select nib: on each clk edge with cpu_bus[7]=0, nib<=~nib. It pairs the CPU's two successive same-address accesses (low/high or ins/v).
- Memory index = {bank, latch, nib}, 9 bits, where bank=cpu_bus[6] (valid only while strobe=0).
- Read path, combinational:
  - cpu_rd[3:0]=mem[index] when strobe=0.
  - cpu_rd[3:0]=4'h0 when strobe=1.
  - cpu_rd[5:4]=dev_rdata, pass-through.
- RAM write: on a clk edge with strobe=0 and [5]=0, mem[index]<=cpu_bus[3:0]. A read of the same index in the same cycle returns the old data.
- Device write:
  - Registered, 1-cycle latency.
  - dev_we<=(strobe=0 && [4]=0); dev_wdata<=cpu_bus[3:0] when written.
  - dev_addr=latch, constant across the pulse.
  - Both [5]=0 and [4]=0 in one cycle: both writes occur.
- Loader FSM states:
  - IDLE: cpu_reset=0. load_en=1 -> LOAD with load_ptr<=0.
  - LOAD: cpu_reset=1. On load_valid: mem[{1'b1,load_ptr}]<=load_data, load_ptr++. The 8-bit load_ptr wraps 255->0. load_en=0 -> RELEASE.
  - RELEASE: cpu_reset=1 for exactly 1 cycle, then IDLE.
- Loader priority:
  - In LOAD and RELEASE, CPU RAM and device writes are ignored.
  - A load_valid on the cycle load_en falls is still written.
- Reset mid-load: FSM goes to IDLE, load_ptr=0. Nibbles already written are kept; the CPU still sees 1 reset cycle after.
- Reset asserted with load_en=1: after release the FSM enters LOAD on the next cycle.

Decomposition:
- Package moonbase_bus_pkg holds the bus bit-position constants (STROBE=7, BANK=6, RAM_WE_N=5, DEV_WE_N=4), bank encodings, and the loader state enum {IDLE, LOAD, RELEASE}.
- One sub-module, moonbase_nibble_ram:
  - 512×4 array with 1 sync write port and 1 async read port.
  - Write-port mux (loader vs CPU) lives in the parent.

Test Plan:
- Load 4 nibbles A,B,C,D with load_en=1 -> code mem[256..259]=A,B,C,D. cpu_reset high throughout plus 1 cycle after load_en falls.
- strobe with addr 0x05, then two strobe=0 cycles with bank=1 -> cpu_rd[3:0] shows mem[0x10A] then mem[0x10B].
- Data write: strobe addr 0x12, then {bank0,ram_we_n=0,data 3} and {…,data 9} -> mem[0x024]=3, mem[0x025]=9; code bank unchanged.
- Device write: strobe addr 0x40, then cpu_bus=8'b0010_0110 -> next cycle dev_we=1 for 1 cycle, dev_wdata=6, dev_addr=0x40. Also dev_rdata=2'b10 -> cpu_rd[5:4]=2'b10 same cycle.
- Loader wrap and reset: 257 valid nibbles -> nibble 256 overwrites mem[256]. Reset mid-load after 3 nibbles -> IDLE, load_ptr=0, cpu_reset released 1 cycle after reset drops.
- CPU write attempted during LOAD with ram_we_n=0 -> data bank unmodified.

Source files
------------

// File: rtl/moonbase_bus_pkg.sv
// ---------------------------------------------------------------------------
// moonbase_bus_pkg
//   Shared definitions for the moonbase external-bus bridge: bit positions of
//   the multiplexed CPU output bus, bank encodings for the nibble RAM, nibble
//   width, and the program-loader state type.
// ---------------------------------------------------------------------------
package moonbase_bus_pkg;

    // Bit positions inside the CPU's 8-bit io_out bus.
    localparam int STROBE   = 7;  // 1: bus carries an address
    localparam int BANK     = 6;  // data phase: 1 code, 0 data
    localparam int RAM_WE_N = 5;  // data phase: RAM write, active low
    localparam int DEV_WE_N = 4;  // data phase: device write, active low

    // Width of one bus data nibble / one RAM word.
    localparam int NIB_W = 4;

    // Bank select values (top bit of the RAM index).
    localparam logic BANK_CODE = 1'b1;
    localparam logic BANK_DATA = 1'b0;

    // Program loader: IDLE lets the CPU run, LOAD holds it in reset while
    // code memory is filled, RELEASE adds one more reset cycle at the end.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/moonbase_nibble_ram.sv
// ---------------------------------------------------------------------------
// moonbase_nibble_ram
//   2**AW x DW storage with one synchronous write port and one asynchronous
//   read port. A read of the address being written in the same cycle returns
//   the old contents (the write lands on the clock edge).
//
// Ports:
//   clk    in   clock
//   we     in   write enable, sampled on the rising edge
//   waddr  in   AW  write address
//   wdata  in   DW  write data
//   raddr  in   AW  read address (combinational read)
//   rdata  out  DW  read data
// ---------------------------------------------------------------------------
module moonbase_nibble_ram #(
    parameter int AW = 9,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // NOTE: the array has no reset; clearing it would turn a RAM macro into
    // a huge flop bank, and loaded code must survive a CPU reset anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/moonbase_bus_bridge.sv
// ---------------------------------------------------------------------------
// moonbase_bus_bridge
//   External-bus target for the 8-bit moonbase CPU. Demultiplexes the CPU's
//   8-bit output bus into an address latch, a nibble-paired code/data RAM and
//   a small device port, and returns 6 read-data bits. A nibble-serial loader
//   can hold the CPU in reset while it fills the code bank.
//
// Parameters:
//   ABITS  width of the latched bus address (7)
//   DEV_W  device write-data width; must equal the bus nibble width (4)
//
// Ports:
//   clk         in   clock
//   reset       in   synchronous, active-high reset
//   cpu_bus     in   8      CPU io_out (strobe / address / control / wdata)
//   cpu_rd      out  6      to CPU io_in[7:2]: {dev_rdata, ram nibble}
//   cpu_reset   out  1      to CPU io_in[1]
//   load_en     in   1      loader active
//   load_valid  in   1      load_data qualifier
//   load_data   in   4      nibble to load into the code bank
//   dev_addr    out  ABITS  latched address for devices
//   dev_wdata   out  DEV_W  device write data
//   dev_we      out  1      one-cycle device write pulse
//   dev_rdata   in   2      device read data at dev_addr
// ---------------------------------------------------------------------------
module moonbase_bus_bridge
    import moonbase_bus_pkg::*;
#(
    parameter int ABITS = 7,
    parameter int DEV_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       cpu_bus,
    output logic [5:0]       cpu_rd,
    output logic             cpu_reset,
    input  logic             load_en,
    input  logic             load_valid,
    input  logic [NIB_W-1:0] load_data,
    output logic [ABITS-1:0] dev_addr,
    output logic [DEV_W-1:0] dev_wdata,
    output logic             dev_we,
    input  logic [1:0]       dev_rdata
);

    // RAM index is {bank, address, nibble}; the loader covers the whole code
    // bank, so its pointer is one bit wider than the bus address.
    localparam int MEM_AW     = ABITS + 2;
    localparam int LOAD_PTR_W = ABITS + 1;

    loader_state_t          state;
    logic [ABITS-1:0]       addr_latch;
    logic                   nib;
    logic [LOAD_PTR_W-1:0]  load_ptr;
    logic                   cpu_reset_q;

    logic                   strobe;
    logic                   cpu_owns_bus;
    logic                   cpu_ram_we;
    logic                   cpu_dev_we;
    logic                   load_we;
    logic [MEM_AW-1:0]      cpu_index;
    logic                   ram_we;
    logic [MEM_AW-1:0]      ram_waddr;
    logic [NIB_W-1:0]       ram_wdata;
    logic [NIB_W-1:0]       ram_rdata;

    assign strobe    = cpu_bus[STROBE];
    assign cpu_index = {cpu_bus[BANK], addr_latch, nib};

    // The CPU may only write while the loader is idle and not under reset.
    assign cpu_owns_bus = (state == IDLE) && !reset;
    assign cpu_ram_we   = cpu_owns_bus && !strobe && !cpu_bus[RAM_WE_N];
    assign cpu_dev_we   = cpu_owns_bus && !strobe && !cpu_bus[DEV_WE_N];
    assign load_we      = (state == LOAD) && load_valid && !reset;

    // Loader and CPU writes are mutually exclusive by state; the loader
    // still takes the port first.
    assign ram_we    = load_we || cpu_ram_we;
    assign ram_waddr = load_we ? {BANK_CODE, load_ptr} : cpu_index;
    assign ram_wdata = load_we ? load_data : cpu_bus[NIB_W-1:0];

    moonbase_nibble_ram #(
        .AW (MEM_AW),
        .DW (NIB_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (cpu_index),
        .rdata (ram_rdata)
    );

    // During an address strobe the bus carries no bank bit, so the RAM
    // nibble is forced to zero rather than showing an arbitrary location.
    assign cpu_rd    = {dev_rdata, (strobe ? {NIB_W{1'b0}} : ram_rdata)};
    assign dev_addr  = addr_latch;

    // The CPU also sees reset combinationally while reset is asserted.
    assign cpu_reset = reset || cpu_reset_q;

    // Address latch and nibble pairing: two successive data-phase cycles at
    // one address select nibble 0 then nibble 1.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_latch <= '0;
            nib        <= 1'b0;
        end else if (strobe) begin
            addr_latch <= cpu_bus[ABITS-1:0];
            nib        <= 1'b0;
        end else begin
            nib        <= ~nib;
        end
    end

    // Device write port: registered pulse, data held until the next write.
    always_ff @(posedge clk) begin
        if (reset) begin
            dev_we    <= 1'b0;
            dev_wdata <= '0;
        end else begin
            dev_we <= cpu_dev_we;
            if (cpu_dev_we) begin
                dev_wdata <= cpu_bus[DEV_W-1:0];
            end
        end
    end

    // Loader FSM. cpu_reset_q is set from the next state so that the CPU
    // reset output is registered and lines up with LOAD/RELEASE; reset
    // itself leaves it high for one more cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            load_ptr    <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load_en) begin
                        state       <= LOAD;
                        load_ptr    <= '0;
                        cpu_reset_q <= 1'b1;
                    end else begin
                        cpu_reset_q <= 1'b0;
                    end
                end
                LOAD: begin
                    // A nibble offered on the cycle load_en drops is kept.
                    if (load_valid) begin
                        load_ptr <= load_ptr + LOAD_PTR_W'(1);
                    end
                    if (!load_en) begin
                        state <= RELEASE;
                    end
                    cpu_reset_q <= 1'b1;
                end
                RELEASE: begin
                    state       <= IDLE;
                    cpu_reset_q <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    cpu_reset_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_moonbase_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_moonbase_bus_bridge
//   Self-checking bench for moonbase_bus_bridge. Directed scenarios compare
//   against values the bench chose itself; a randomized phase compares every
//   cycle against a behavioural model (memory array plus a few flags).
// ---------------------------------------------------------------------------
module tb_moonbase_bus_bridge;

    logic       clk;
    logic       reset;
    logic [7:0] cpu_bus;
    logic [5:0] cpu_rd;
    logic       cpu_reset;
    logic       load_en;
    logic       load_valid;
    logic [3:0] load_data;
    logic [6:0] dev_addr;
    logic [3:0] dev_wdata;
    logic       dev_we;
    logic [1:0] dev_rdata;

    int errors = 0;
    int checks = 0;

    moonbase_bus_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_bus    (cpu_bus),
        .cpu_rd     (cpu_rd),
        .cpu_reset  (cpu_reset),
        .load_en    (load_en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_we     (dev_we),
        .dev_rdata  (dev_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    logic [3:0] mdl_mem   [512];
    bit         mdl_valid [512];
    logic [6:0] mdl_latch;
    bit         mdl_nib;
    int         mdl_ptr;
    bit         mdl_loading;
    bit         mdl_releasing;
    bit         mdl_hold;
    bit         mdl_dev_we;
    logic [3:0] mdl_dev_wdata;

    initial begin
        for (int i = 0; i < 512; i++) mdl_valid[i] = 1'b0;
        mdl_latch = 0; mdl_nib = 0; mdl_ptr = 0;
        mdl_loading = 0; mdl_releasing = 0; mdl_hold = 1;
        mdl_dev_we = 0; mdl_dev_wdata = 0;
    end

    function automatic int cpu_idx();
        return int'(cpu_bus[6]) * 256 + int'(mdl_latch) * 2 + int'(mdl_nib);
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit cpu_ok;
        int idx;
        if (reset) begin
            mdl_latch = 0; mdl_nib = 0; mdl_ptr = 0;
            mdl_dev_we = 0; mdl_dev_wdata = 0;
            mdl_loading = 0; mdl_releasing = 0; mdl_hold = 1;
            return;
        end
        cpu_ok = !mdl_loading && !mdl_releasing;
        idx    = cpu_idx();
        mdl_dev_we = 0;
        if (!cpu_bus[7]) begin
            if (cpu_ok && !cpu_bus[5]) begin
                mdl_mem[idx] = cpu_bus[3:0];
                mdl_valid[idx] = 1'b1;
            end
            if (cpu_ok && !cpu_bus[4]) begin
                mdl_dev_we = 1;
                mdl_dev_wdata = cpu_bus[3:0];
            end
            mdl_nib = !mdl_nib;
        end else begin
            mdl_latch = cpu_bus[6:0];
            mdl_nib = 0;
        end
        if (mdl_releasing) begin
            mdl_releasing = 0;
        end else if (mdl_loading) begin
            if (load_valid) begin
                mdl_mem[256 + mdl_ptr] = load_data;
                mdl_valid[256 + mdl_ptr] = 1'b1;
                mdl_ptr = (mdl_ptr + 1) % 256;
            end
            if (!load_en) begin
                mdl_loading = 0;
                mdl_releasing = 1;
            end
        end else if (load_en) begin
            mdl_loading = 1;
            mdl_ptr = 0;
        end
        mdl_hold = 0;
    endtask

    // One clock: model follows the rising edge, control returns just after
    // the falling edge so new inputs can be driven.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1; cpu_bus = 8'h80; load_en = 0; load_valid = 0;
        step(); step();
        #1;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (dev_we !== 1'b0) begin errors++; $display("FAIL rst_dev_we: got %b want 0", dev_we); end
        checks++; if (dev_wdata !== 4'h0) begin errors++; $display("FAIL rst_dev_wdata: got %h want 0", dev_wdata); end
        checks++; if (dev_addr !== 7'h00) begin errors++; $display("FAIL rst_dev_addr: got %h want 00", dev_addr); end
        checks++; if (cpu_rd[3:0] !== 4'h0) begin errors++; $display("FAIL rst_strobe_rd: got %h want 0", cpu_rd[3:0]); end
        reset = 0;
        #1;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_hold_cycle: got %b want 1", cpu_reset); end
        step(); #1;
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL rst_released: got %b want 0", cpu_reset); end
    endtask

    task automatic test_load();
        logic [3:0] v [4];
        for (int i = 0; i < 4; i++) v[i] = 4'($urandom);
        cpu_bus = 8'h80; load_en = 1; load_valid = 0;
        #1;
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL load_idle_rst: got %b want 0", cpu_reset); end
        step();
        for (int i = 0; i < 4; i++) begin
            // Last nibble arrives on the same cycle load_en drops.
            load_valid = 1; load_data = v[i]; load_en = (i != 3);
            #1;
            checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL load_rst_%0d: got %b want 1", i, cpu_reset); end
            step();
        end
        load_valid = 0; load_en = 0;
        #1;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL load_release_rst: got %b want 1", cpu_reset); end
        step(); #1;
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL load_done_rst: got %b want 0", cpu_reset); end
        for (int a = 0; a < 2; a++) begin
            cpu_bus = {1'b1, 7'(a)}; step();
            for (int n = 0; n < 2; n++) begin
                cpu_bus = 8'h70; #1;
                checks++; if (cpu_rd[3:0] !== v[a*2+n]) begin errors++; $display("FAIL load_mem_%0d: got %h want %h", 256+a*2+n, cpu_rd[3:0], v[a*2+n]); end
                step();
            end
        end
    endtask

    task automatic test_code_read();
        logic [3:0] p, q;
        p = 4'($urandom); q = 4'($urandom);
        cpu_bus = 8'h85; step();
        cpu_bus = {4'b0101, p}; step();
        cpu_bus = {4'b0101, q}; step();
        cpu_bus = 8'h85; #1;
        checks++; if (cpu_rd[3:0] !== 4'h0) begin errors++; $display("FAIL code_strobe_rd: got %h want 0", cpu_rd[3:0]); end
        step();
        cpu_bus = 8'h70; #1;
        checks++; if (cpu_rd[3:0] !== p) begin errors++; $display("FAIL code_rd_10a: got %h want %h", cpu_rd[3:0], p); end
        step();
        cpu_bus = 8'h70; #1;
        checks++; if (cpu_rd[3:0] !== q) begin errors++; $display("FAIL code_rd_10b: got %h want %h", cpu_rd[3:0], q); end
        step();
    endtask

    task automatic test_data_write();
        logic [3:0] r, s;
        r = 4'($urandom); s = 4'($urandom);
        cpu_bus = 8'h92; step();
        cpu_bus = {4'b0101, r}; step();
        cpu_bus = {4'b0101, s}; step();
        cpu_bus = 8'h92; step();
        cpu_bus = 8'h13; step();
        cpu_bus = 8'h19; step();
        cpu_bus = 8'h92; step();
        cpu_bus = 8'h30; #1;
        checks++; if (cpu_rd[3:0] !== 4'h3) begin errors++; $display("FAIL data_rd_024: got %h want 3", cpu_rd[3:0]); end
        step();
        cpu_bus = 8'h30; #1;
        checks++; if (cpu_rd[3:0] !== 4'h9) begin errors++; $display("FAIL data_rd_025: got %h want 9", cpu_rd[3:0]); end
        step();
        cpu_bus = 8'h92; step();
        cpu_bus = 8'h70; #1;
        checks++; if (cpu_rd[3:0] !== r) begin errors++; $display("FAIL code_kept_124: got %h want %h", cpu_rd[3:0], r); end
        step();
        cpu_bus = 8'h70; #1;
        checks++; if (cpu_rd[3:0] !== s) begin errors++; $display("FAIL code_kept_125: got %h want %h", cpu_rd[3:0], s); end
        step();
        // Read-during-write returns the old nibble.
        cpu_bus = 8'h92; step();
        cpu_bus = 8'h1C; #1;
        checks++; if (cpu_rd[3:0] !== 4'h3) begin errors++; $display("FAIL rdw_old: got %h want 3", cpu_rd[3:0]); end
        step();
        cpu_bus = 8'h92; step();
        cpu_bus = 8'h30; #1;
        checks++; if (cpu_rd[3:0] !== 4'hC) begin errors++; $display("FAIL rdw_new: got %h want c", cpu_rd[3:0]); end
        step();
    endtask

    task automatic test_device();
        cpu_bus = 8'hC0; dev_rdata = 2'b00; step();
        cpu_bus = 8'h26; dev_rdata = 2'b10; #1;
        checks++; if (cpu_rd[5:4] !== 2'b10) begin errors++; $display("FAIL dev_rdata_pass: got %b want 10", cpu_rd[5:4]); end
        checks++; if (dev_we !== 1'b0) begin errors++; $display("FAIL dev_we_early: got %b want 0", dev_we); end
        step();
        cpu_bus = 8'h30; dev_rdata = 2'b01; #1;
        checks++; if (dev_we !== 1'b1) begin errors++; $display("FAIL dev_we_pulse: got %b want 1", dev_we); end
        checks++; if (dev_wdata !== 4'h6) begin errors++; $display("FAIL dev_wdata: got %h want 6", dev_wdata); end
        checks++; if (dev_addr !== 7'h40) begin errors++; $display("FAIL dev_addr: got %h want 40", dev_addr); end
        checks++; if (cpu_rd[5:4] !== 2'b01) begin errors++; $display("FAIL dev_rdata_pass2: got %b want 01", cpu_rd[5:4]); end
        step(); #1;
        checks++; if (dev_we !== 1'b0) begin errors++; $display("FAIL dev_we_one_cycle: got %b want 0", dev_we); end
        checks++; if (dev_wdata !== 4'h6) begin errors++; $display("FAIL dev_wdata_hold: got %h want 6", dev_wdata); end
        // RAM and device write in the same cycle.
        cpu_bus = 8'hC1; step();
        cpu_bus = 8'h05; step();
        cpu_bus = 8'h30; #1;
        checks++; if (dev_we !== 1'b1) begin errors++; $display("FAIL both_dev_we: got %b want 1", dev_we); end
        checks++; if (dev_wdata !== 4'h5) begin errors++; $display("FAIL both_dev_wdata: got %h want 5", dev_wdata); end
        checks++; if (dev_addr !== 7'h41) begin errors++; $display("FAIL both_dev_addr: got %h want 41", dev_addr); end
        step();
        cpu_bus = 8'hC1; step();
        cpu_bus = 8'h30; #1;
        checks++; if (cpu_rd[3:0] !== 4'h5) begin errors++; $display("FAIL both_ram_082: got %h want 5", cpu_rd[3:0]); end
        step();
    endtask

    task automatic test_load_blocks_cpu();
        cpu_bus = 8'h80; load_en = 1; load_valid = 0; step();
        cpu_bus = 8'h92; step();
        cpu_bus = 8'h07; step();
        cpu_bus = 8'h30; #1;
        checks++; if (dev_we !== 1'b0) begin errors++; $display("FAIL blk_dev_we_load: got %b want 0", dev_we); end
        load_en = 0; step();
        cpu_bus = 8'h07; step();
        cpu_bus = 8'h92; #1;
        checks++; if (dev_we !== 1'b0) begin errors++; $display("FAIL blk_dev_we_release: got %b want 0", dev_we); end
        step();
        cpu_bus = 8'h30; #1;
        checks++; if (cpu_rd[3:0] !== 4'hC) begin errors++; $display("FAIL blk_ram_024: got %h want c", cpu_rd[3:0]); end
        step();
        cpu_bus = 8'h30; #1;
        checks++; if (cpu_rd[3:0] !== 4'h9) begin errors++; $display("FAIL blk_ram_025: got %h want 9", cpu_rd[3:0]); end
        step();
    endtask

    task automatic test_load_wrap();
        logic [3:0] w [257];
        cpu_bus = 8'h80; load_en = 1; load_valid = 0; step();
        for (int i = 0; i < 257; i++) begin
            w[i] = 4'($urandom);
            load_valid = 1; load_data = w[i]; step();
        end
        load_valid = 0; load_en = 0; step();
        step(); #1;
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL wrap_done_rst: got %b want 0", cpu_reset); end
        cpu_bus = 8'h80; step();
        cpu_bus = 8'h70; #1;
        checks++; if (cpu_rd[3:0] !== w[256]) begin errors++; $display("FAIL wrap_mem_256: got %h want %h", cpu_rd[3:0], w[256]); end
        step();
        cpu_bus = 8'h70; #1;
        checks++; if (cpu_rd[3:0] !== w[1]) begin errors++; $display("FAIL wrap_mem_257: got %h want %h", cpu_rd[3:0], w[1]); end
        step();
        cpu_bus = 8'hFF; step();
        cpu_bus = 8'h70; #1;
        checks++; if (cpu_rd[3:0] !== w[254]) begin errors++; $display("FAIL wrap_mem_510: got %h want %h", cpu_rd[3:0], w[254]); end
        step();
        cpu_bus = 8'h70; #1;
        checks++; if (cpu_rd[3:0] !== w[255]) begin errors++; $display("FAIL wrap_mem_511: got %h want %h", cpu_rd[3:0], w[255]); end
        step();
    endtask

    task automatic test_reset_mid_load();
        logic [3:0] x [3];
        logic [3:0] yv, fv;
        for (int i = 0; i < 3; i++) x[i] = 4'($urandom);
        cpu_bus = 8'h80; load_en = 1; load_valid = 0; step();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1; load_data = x[i]; step();
        end
        load_valid = 0; load_en = 0; reset = 1; #1;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL mid_rst_during: got %b want 1", cpu_reset); end
        step();
        reset = 0; #1;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL mid_rst_hold: got %b want 1", cpu_reset); end
        step(); #1;
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL mid_rst_idle: got %b want 0", cpu_reset); end
        // Pointer restarted: one nibble lands at 256, earlier ones kept.
        yv = 4'($urandom);
        load_en = 1; step();
        load_valid = 1; load_data = yv; load_en = 0; step();
        load_valid = 0; step();
        cpu_bus = 8'h80; step();
        cpu_bus = 8'h70; #1;
        checks++; if (cpu_rd[3:0] !== yv) begin errors++; $display("FAIL mid_ptr0_256: got %h want %h", cpu_rd[3:0], yv); end
        step();
        cpu_bus = 8'h70; #1;
        checks++; if (cpu_rd[3:0] !== x[1]) begin errors++; $display("FAIL mid_kept_257: got %h want %h", cpu_rd[3:0], x[1]); end
        step();
        cpu_bus = 8'h81; step();
        cpu_bus = 8'h70; #1;
        checks++; if (cpu_rd[3:0] !== x[2]) begin errors++; $display("FAIL mid_kept_258: got %h want %h", cpu_rd[3:0], x[2]); end
        step();
        // Reset held with load_en=1: LOAD is entered on the first cycle after.
        fv = 4'($urandom);
        cpu_bus = 8'h80; reset = 1; load_en = 1; load_valid = 0; step();
        reset = 0; load_valid = 1; load_data = ~fv; #1;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rle_hold: got %b want 1", cpu_reset); end
        step();
        load_data = fv; load_en = 0; #1;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rle_load: got %b want 1", cpu_reset); end
        step();
        load_valid = 0; #1;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rle_release: got %b want 1", cpu_reset); end
        step(); #1;
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL rle_idle: got %b want 0", cpu_reset); end
        cpu_bus = 8'h80; step();
        cpu_bus = 8'h70; #1;
        checks++; if (cpu_rd[3:0] !== fv) begin errors++; $display("FAIL rle_mem_256: got %h want %h", cpu_rd[3:0], fv); end
        step();
        cpu_bus = 8'h70; #1;
        checks++; if (cpu_rd[3:0] !== x[1]) begin errors++; $display("FAIL rle_mem_257: got %h want %h", cpu_rd[3:0], x[1]); end
        step();
    endtask

    task automatic test_random();
        bit exp_rst;
        int idx;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) cpu_bus = {1'b1, 4'b0000, 3'($urandom_range(0, 7))};
            else                           cpu_bus = {1'b0, 7'($urandom)};
            if ($urandom_range(0, 15) == 0) load_en = ~load_en;
            load_valid = 1'($urandom);
            load_data  = 4'($urandom);
            dev_rdata  = 2'($urandom);
            #1;
            exp_rst = reset || mdl_hold || mdl_loading || mdl_releasing;
            checks++; if (cpu_reset !== exp_rst) begin errors++; $display("FAIL rnd_cpu_reset c=%0d: got %b want %b", c, cpu_reset, exp_rst); end
            checks++; if (dev_we !== mdl_dev_we) begin errors++; $display("FAIL rnd_dev_we c=%0d: got %b want %b", c, dev_we, mdl_dev_we); end
            checks++; if (dev_wdata !== mdl_dev_wdata) begin errors++; $display("FAIL rnd_dev_wdata c=%0d: got %h want %h", c, dev_wdata, mdl_dev_wdata); end
            checks++; if (dev_addr !== mdl_latch) begin errors++; $display("FAIL rnd_dev_addr c=%0d: got %h want %h", c, dev_addr, mdl_latch); end
            checks++; if (cpu_rd[5:4] !== dev_rdata) begin errors++; $display("FAIL rnd_rd_dev c=%0d: got %b want %b", c, cpu_rd[5:4], dev_rdata); end
            if (cpu_bus[7]) begin
                checks++; if (cpu_rd[3:0] !== 4'h0) begin errors++; $display("FAIL rnd_rd_strobe c=%0d: got %h want 0", c, cpu_rd[3:0]); end
            end else begin
                idx = cpu_idx();
                if (mdl_valid[idx]) begin
                    checks++; if (cpu_rd[3:0] !== mdl_mem[idx]) begin errors++; $display("FAIL rnd_rd_mem c=%0d idx=%0d: got %h want %h", c, idx, cpu_rd[3:0], mdl_mem[idx]); end
                end
            end
            step();
        end
    endtask

    initial begin
        reset = 1; cpu_bus = 8'h80; load_en = 0; load_valid = 0;
        load_data = 4'h0; dev_rdata = 2'b00;
        test_reset();
        test_load();
        test_code_read();
        test_data_write();
        test_device();
        test_load_blocks_cpu();
        test_load_wrap();
        test_reset_mid_load();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
